// File: rtl/tetris_pkg.sv
// Shared state encoding for the tetris game controller and its helpers.
package tetris_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_GEN   = 3'd1,
      S_MOVE  = 3'd2,
      S_LAND  = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5
   } state_t;

endpackage

// File: rtl/tetris_drop_timer.sv
// Gravity timer: emits one drop_tick every period cycles while enabled;
// the period shrinks with level down to a floor.
module tetris_drop_timer #(
   parameter int DROP_TICKS = 50,
   parameter int LEVEL_STEP = 4,
   parameter int MIN_TICKS  = 2
) (
   input  logic       clka,
   input  logic       restart_n,
   input  logic       en,
   input  logic       clr,
   input  logic [2:0] level,
   output logic       drop_tick
);

   localparam int CNT_W = $clog2(DROP_TICKS + 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] period;
   int               period_raw;

   always_comb begin
      period_raw = DROP_TICKS - int'(level) * LEVEL_STEP;
      if (period_raw < MIN_TICKS) period_raw = MIN_TICKS;
      period = CNT_W'(period_raw);
   end

   assign drop_tick = en && (count == period - 1'b1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clka) begin
      if (!restart_n || clr) begin
         count <= '0;
      end else if (en) begin
         count <= drop_tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Main game sequencer GEN -> MOVE -> LAND -> CLEAR with gravity timer,
// top-down multi-row clearing, line score and level speed-up.
module tetris_game_ctrl
   import tetris_pkg::*;
#(
   parameter int ROWS            = 16,
   parameter int ROW_IDX_W       = 4,
   parameter int DROP_TICKS      = 50,
   parameter int LEVEL_STEP      = 4,
   parameter int MIN_TICKS       = 2,
   parameter int LINES_PER_LEVEL = 10,
   parameter int MAX_LEVEL       = 7,
   parameter int SCORE_W         = 16
) (
   input  logic                 clka,
   input  logic                 restart_n,
   input  logic                 start,
   input  logic                 pause,
   input  logic                 new_piece,
   input  logic                 touched,
   input  logic                 land_done,
   input  logic [ROWS-1:0]      full_rows,
   input  logic                 clear_done,
   input  logic                 game_over,
   output logic [2:0]           state,
   output logic                 start_gen,
   output logic                 start_move,
   output logic                 start_land,
   output logic                 start_clear,
   output logic [ROW_IDX_W-1:0] clear_row,
   output logic                 drop_tick,
   output logic [SCORE_W-1:0]   lines_cleared,
   output logic [2:0]           level
);

   localparam int LVL_CNT_W = $clog2(LINES_PER_LEVEL + 1);

   state_t                 state_q, state_d;
   logic [ROWS-1:0]        mask_q;
   logic [ROWS-1:0]        mask_left;
   logic [LVL_CNT_W-1:0]   lvl_cnt;
   logic                   row_done;
   logic                   timer_en;
   logic                   timer_clr;

   // Ascending scan: the last set bit seen is the highest one.
   function automatic logic [ROW_IDX_W-1:0] hi_bit(input logic [ROWS-1:0] v);
      hi_bit = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (v[i]) hi_bit = ROW_IDX_W'(i);
      end
   endfunction

   assign mask_left = mask_q & ~(ROWS'(1) << clear_row);
   assign row_done  = (state_q == S_CLEAR) && clear_done && !game_over;
   assign state     = state_q;

   always_comb begin
      // NOTE: the default assignment first keeps this block free of latches.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_GEN;
         S_GEN:   if (game_over) state_d = S_OVER;
                  else if (new_piece) state_d = S_MOVE;
         S_MOVE:  if (game_over) state_d = S_OVER;
                  else if (touched) state_d = S_LAND;
         S_LAND:  if (game_over) state_d = S_OVER;
                  else if (land_done) state_d = (full_rows != '0) ? S_CLEAR : S_GEN;
         S_CLEAR: if (game_over) state_d = S_OVER;
                  else if (clear_done && mask_left == '0) state_d = S_GEN;
         S_OVER:  state_d = S_OVER;
         default: state_d = S_IDLE;
      endcase
   end

   assign timer_en  = (state_q == S_MOVE) && !pause && !touched && !game_over;
   assign timer_clr = (state_q != S_MOVE) || touched;

   tetris_drop_timer #(
      .DROP_TICKS (DROP_TICKS),
      .LEVEL_STEP (LEVEL_STEP),
      .MIN_TICKS  (MIN_TICKS)
   ) u_drop_timer (
      .clka      (clka),
      .restart_n (restart_n),
      .en        (timer_en),
      .clr       (timer_clr),
      .level     (level),
      .drop_tick (drop_tick)
   );

   always_ff @(posedge clka) begin
      if (!restart_n) begin
         state_q       <= S_IDLE;
         start_gen     <= 1'b0;
         start_move    <= 1'b0;
         start_land    <= 1'b0;
         start_clear   <= 1'b0;
         clear_row     <= '0;
         mask_q        <= '0;
         lines_cleared <= '0;
         lvl_cnt       <= '0;
         level         <= '0;
      end else begin
         state_q     <= state_d;
         start_gen   <= (state_d == S_GEN)  && (state_q != S_GEN);
         start_move  <= (state_d == S_MOVE) && (state_q != S_MOVE);
         start_land  <= (state_d == S_LAND) && (state_q != S_LAND);
         start_clear <= 1'b0;

         if (state_q == S_LAND && state_d == S_CLEAR) begin
            mask_q      <= full_rows;
            clear_row   <= hi_bit(full_rows);
            start_clear <= 1'b1;
         end

         if (row_done) begin
            mask_q <= mask_left;
            if (mask_left != '0) begin
               clear_row   <= hi_bit(mask_left);
               start_clear <= 1'b1;
            end
            if (lines_cleared != '1) lines_cleared <= lines_cleared + 1'b1;
            if (lvl_cnt == LVL_CNT_W'(LINES_PER_LEVEL - 1)) begin
               lvl_cnt <= '0;
               if (level != 3'(MAX_LEVEL)) level <= level + 1'b1;
            end else begin
               lvl_cnt <= lvl_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Self-checking bench for tetris_game_ctrl: vector table, directed corner
// sequences and randomized games against a line/level/period model.
module tb_tetris_game_ctrl;

   localparam int ROWS = 16;
   localparam int DT   = 8;
   localparam int LS   = 2;
   localparam int MT   = 2;
   localparam int LPL  = 2;
   localparam int ML   = 7;

   logic        clka = 1'b0;
   logic        restart_n, start, pause, new_piece, touched, land_done, clear_done, game_over;
   logic [15:0] full_rows;
   logic [2:0]  state;
   logic        start_gen, start_move, start_land, start_clear, drop_tick;
   logic [3:0]  clear_row;
   logic [15:0] lines_cleared;
   logic [2:0]  level;
   logic [3:0]  pulses;

   int n_tests = 0;
   int n_fail  = 0;
   int lines_m = 0;

   tetris_game_ctrl #(
      .ROWS(ROWS), .ROW_IDX_W(4), .DROP_TICKS(DT), .LEVEL_STEP(LS), .MIN_TICKS(MT),
      .LINES_PER_LEVEL(LPL), .MAX_LEVEL(ML), .SCORE_W(16)
   ) dut (
      .clka(clka), .restart_n(restart_n), .start(start), .pause(pause),
      .new_piece(new_piece), .touched(touched), .land_done(land_done),
      .full_rows(full_rows), .clear_done(clear_done), .game_over(game_over),
      .state(state), .start_gen(start_gen), .start_move(start_move),
      .start_land(start_land), .start_clear(start_clear), .clear_row(clear_row),
      .drop_tick(drop_tick), .lines_cleared(lines_cleared), .level(level)
   );

   always #5 clka = ~clka;

   assign pulses = {start_gen, start_move, start_land, start_clear};

   typedef struct packed {
      logic       rst_n;
      logic       start;
      logic       new_piece;
      logic       touched;
      logic       land_done;
      logic       game_over;
      logic [2:0] exp_state;
      logic [3:0] exp_pulses;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; pause = 0; new_piece = 0; touched = 0;
      land_done = 0; clear_done = 0; game_over = 0; full_rows = '0;
   endtask

   function automatic int model_level();
      return (lines_m / LPL > ML) ? ML : lines_m / LPL;
   endfunction

   function automatic int model_period();
      int p;
      p = DT - LS * model_level();
      return (p < MT) ? MT : p;
   endfunction

   task automatic do_reset();
      restart_n = 0; tick(); restart_n = 1;
      lines_m = 0;
   endtask

   task automatic to_move();
      new_piece = 1; tick(); new_piece = 0;
      check("enter move state", state, 2);
      check("start_move pulse", start_move, 1);
   endtask

   // Cycles from the current sample until drop_tick is seen, counting this one.
   task automatic measure_period(input int exp);
      int idx;
      idx = -1;
      for (int i = 0; i < 40 && idx < 0; i++) begin
         if (drop_tick) idx = i;
         else tick();
      end
      check("cycles to drop_tick", idx + 1, exp);
   endtask

   task automatic land(input logic [15:0] mask);
      int q[$];
      touched = 1; tick(); touched = 0;
      check("enter land state", state, 3);
      check("start_land pulse", start_land, 1);
      full_rows = mask; land_done = 1; tick(); land_done = 0; full_rows = '0;
      for (int r = ROWS - 1; r >= 0; r--) if (mask[r]) q.push_back(r);
      if (q.size() == 0) begin
         check("empty mask to gen", state, 1);
         check("start_gen after land", start_gen, 1);
      end else begin
         check("enter clear state", state, 4);
         check("first start_clear", start_clear, 1);
         check("first clear_row", clear_row, q[0]);
         while (q.size() > 0) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               check("start_clear single pulse", start_clear, 0);
               check("clear_row held", clear_row, q[0]);
            end
            clear_done = 1; tick(); clear_done = 0;
            void'(q.pop_front());
            lines_m++;
            check("lines_cleared", lines_cleared, lines_m);
            check("level", level, model_level());
            if (q.size() > 0) begin
               check("stay in clear", state, 4);
               check("next start_clear", start_clear, 1);
               check("next clear_row", clear_row, q[0]);
            end else begin
               check("clear done to gen", state, 1);
               check("start_gen after clear", start_gen, 1);
               check("no start_clear at end", start_clear, 0);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      restart_n = 0;

      //            rst st np tc ld go  state  {gen,move,land,clear}
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 4'b0000};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd0, 4'b0000};
      vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'b1000};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd1, 4'b0000};
      vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2, 4'b0100};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd2, 4'b0000};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd3, 4'b0010};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1, 4'b1000};
      vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2, 4'b0100};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 3'd5, 4'b0000};
      vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd5, 4'b0000};
      vecs[11] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 3'd5, 4'b0000};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 4'b0000};
      vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'b1000};
      vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd5, 4'b0000};

      for (int i = 0; i < 15; i++) begin
         restart_n = vecs[i].rst_n;
         start     = vecs[i].start;
         new_piece = vecs[i].new_piece;
         touched   = vecs[i].touched;
         land_done = vecs[i].land_done;
         game_over = vecs[i].game_over;
         tick();
         check($sformatf("vec%0d state", i), state, vecs[i].exp_state);
         check($sformatf("vec%0d pulses", i), pulses, vecs[i].exp_pulses);
         if (i == 0) begin
            check("reset lines_cleared", lines_cleared, 0);
            check("reset level", level, 0);
            check("reset clear_row", clear_row, 0);
         end
      end
      idle_inputs();

      // Gravity cadence and pause hold.
      do_reset();
      start = 1; tick(); start = 0;
      to_move();
      for (int i = 0; i < 24; i++) begin
         check($sformatf("drop_tick cycle %0d", i), drop_tick, (i % 8) == 7);
         tick();
      end
      repeat (3) tick();
      pause = 1;
      for (int i = 0; i < 5; i++) begin
         check("no drop_tick while paused", drop_tick, 0);
         tick();
      end
      pause = 0;
      measure_period(5);

      // Landing with nothing to clear.
      land(16'h0000);
      check("lines after empty land", lines_cleared, 0);

      // Three rows cleared top-down, level-up, faster gravity.
      to_move();
      land(16'h000B);
      check("lines after three rows", lines_cleared, 3);
      check("level after three rows", level, 1);
      to_move();
      measure_period(6);

      // game_over beats touched; OVER holds score until restart.
      touched = 1; game_over = 1; tick(); touched = 0; game_over = 0;
      check("game_over to over", state, 5);
      check("no start_land on game_over", start_land, 0);
      check("lines held in over", lines_cleared, 3);
      check("level held in over", level, 1);
      start = 1; tick(); start = 0;
      check("start ignored in over", state, 5);
      do_reset();
      check("restart to idle", state, 0);
      check("restart clears lines", lines_cleared, 0);
      check("restart clears level", level, 0);

      // Restart in the middle of a multi-row clear.
      start = 1; tick(); start = 0;
      to_move();
      touched = 1; tick(); touched = 0;
      full_rows = 16'h0070; land_done = 1; tick(); land_done = 0; full_rows = '0;
      check("mid-clear first row", clear_row, 6);
      clear_done = 1; tick(); clear_done = 0;
      check("mid-clear second row", clear_row, 5);
      do_reset();
      check("mid-clear restart state", state, 0);
      check("mid-clear restart start_clear", start_clear, 0);
      check("mid-clear restart clear_row", clear_row, 0);
      check("mid-clear restart lines", lines_cleared, 0);
      land_done = 1; clear_done = 1; full_rows = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle ignores handshakes state", state, 0);
         check("idle ignores handshakes clear", start_clear, 0);
      end
      idle_inputs();
      start = 1; tick(); start = 0;
      to_move();
      land(16'h0000);

      // Randomized games against the model.
      for (int p = 0; p < 40; p++) begin
         logic [15:0] mask;
         mask = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom & $urandom & $urandom);
         to_move();
         measure_period(model_period());
         land(mask);
      end
      check("random final lines", lines_cleared, lines_m);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
